ifu_fetch_ctrl: RTL
===================

IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_3000, meaning the reset fetch address.
REQ-002 SHALL have parameter HANDLER_PC, default 32'h0000_4180, meaning the exception entry address.
REQ-003 SHALL have parameter IM_BASE, default 32'h0000_3000, meaning the lowest legal fetch address.
REQ-004 SHALL have parameter IM_LIMIT, default 32'h0000_6FFC, meaning the highest legal fetch address.
REQ-005 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port: reset  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port: stall  input  1  decode not ready; hold PC and fetch register.
REQ-008 SHALL have port: req  input  1  exception/interrupt flush from commit stage.
REQ-009 SHALL have port: eret  input  1  return-from-exception redirect.
REQ-010 SHALL have port: epc  input  32  eret target.
REQ-011 SHALL have port: npc_sel  input  1  branch/jump taken in decode.
REQ-012 SHALL have port: npc  input  32  branch/jump target.
REQ-013 SHALL have port: im_addr  output  32  combinational read address to instruction memory.
REQ-014 SHALL have port: im_instr  input  32  combinational instruction word returned for im_addr.
REQ-015 SHALL have port: f_valid  output  1  fetch register holds a real instruction.
REQ-016 SHALL have port: f_pc  output  32  PC of the fetched word.
REQ-017 SHALL have port: f_instr  output  32  fetched word.
REQ-018 SHALL have port: f_exccode  output  5  fetch exception code: 0 none, 4 AdEL.
REQ-019 SHALL have port: f_count  output  32  count of valid fetches delivered.

Function
REQ-020 SHALL drive im_addr = pc register, with zero-cycle combinational path to memory.
REQ-021 SHALL flag a fetch fault when pc[1:0]!=0, pc<IM_BASE, or pc>IM_LIMIT; all compares unsigned 32-bit.
REQ-022 SHALL resolve next-PC priority per cycle as req > eret > stall > npc_sel > pc+4 (wrap mod 2^32).
REQ-023 SHALL on req: pc<=HANDLER_PC; f_valid<=0, even when stall=1.
REQ-024 SHALL on eret without req: pc<=epc; f_valid<=0, even when stall=1.
REQ-025 SHALL on stall without req/eret: hold pc, f_valid, f_pc, f_instr, f_exccode, f_count unchanged.
REQ-026 SHALL otherwise load f_valid<=1, f_pc<=pc, f_instr<=im_instr, f_exccode<=0; pc<=npc_sel ? npc : pc+4.
REQ-027 SHALL on a faulting fetch load f_instr<=32'h0 (nop), f_exccode<=4, f_valid<=1, f_pc<=faulting pc; the next-PC rule is unchanged.
REQ-028 SHALL keep a two-state FSM: RUN and BUBBLE; req or eret enters BUBBLE; BUBBLE returns to RUN after one cycle unless req/eret reasserts; in BUBBLE, f_valid output is 0 and the fetch of the redirected pc proceeds per REQ-026.
REQ-029 SHALL increment f_count by 1 on each edge that loads f_valid<=1; wraps 32'hFFFF_FFFF->0.
REQ-030 SHALL give a one-cycle fetch latency: the word at im_addr in cycle N appears on f_* in cycle N+1.

Reset
REQ-031 SHALL on reset set pc=PC_INIT, state=RUN, f_valid=0, f_pc=0, f_instr=0, f_exccode=0, f_count=0.
REQ-032 SHALL have reset override req, eret, stall, and npc_sel in the same cycle; a redirect in progress is discarded.

Structure
REQ-033 SHALL take PC_INIT, HANDLER_PC, IM_BASE, IM_LIMIT, EXC_NONE=0, EXC_ADEL=4, and the FSM state encoding from the shared CPU constants package.
REQ-034 SHALL put the alignment and range test in one combinational sub-module, pc_addr_check (in: pc; out: fault).

Verification
REQ-035 SHALL cover: reset, then 3 free cycles with memory returning word=addr -> f_pc 3000, 3004, 3008; f_valid=1 from the 2nd cycle; f_count=3.
REQ-036 SHALL cover: stall=1 for 2 cycles at pc=300C -> f_* frozen, im_addr stays 300C; then fetch resumes 300C, 3010.
REQ-037 SHALL cover: npc_sel=1 with npc=3100 and stall=1 in the same cycle -> pc holds; the redirect to 3100 is taken only once stall drops.
REQ-038 SHALL cover: req=1 together with stall=1 and eret=1 -> next im_addr=4180, f_valid=0 for one cycle, then f_pc=4180.
REQ-039 SHALL cover: eret with epc=3002, then epc=7000 -> each gives f_exccode=4, f_instr=0, and f_pc equal to the faulting pc.
REQ-040 SHALL cover: reset asserted during the BUBBLE state -> next cycle pc=3000, f_valid=0, f_count=0.

Source files
------------

// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared CPU constants for the instruction-fetch unit: address map,
// exception codes and fetch FSM encoding.
package ifu_fetch_ctrl_pkg;

   localparam logic [31:0] DEF_PC_INIT    = 32'h0000_3000;
   localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] DEF_IM_BASE    = 32'h0000_3000;
   localparam logic [31:0] DEF_IM_LIMIT   = 32'h0000_6FFC;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_BUBBLE = 1'b1
   } fetch_state_e;

   function automatic logic pc_misaligned(input logic [31:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pc_addr_check.sv
// Fetch address legality test: word alignment and instruction-memory window.
module pc_addr_check
   import ifu_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
   parameter logic [31:0] IM_LIMIT = DEF_IM_LIMIT
) (
   input  logic [31:0] pc,
   output logic        fault
);

   assign fault = pc_misaligned(pc) | (pc < IM_BASE) | (pc > IM_LIMIT);

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirect handling and the
// single-stage fetch register feeding decode.
//   state     | meaning
//   ST_RUN    | fetch register output is live
//   ST_BUBBLE | first cycle after req/eret redirect; f_valid forced low
module ifu_fetch_ctrl
   import ifu_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] PC_INIT    = DEF_PC_INIT,
   parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
   parameter logic [31:0] IM_BASE    = DEF_IM_BASE,
   parameter logic [31:0] IM_LIMIT   = DEF_IM_LIMIT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        req,
   input  logic        eret,
   input  logic [31:0] epc,
   input  logic        npc_sel,
   input  logic [31:0] npc,
   output logic [31:0] im_addr,
   input  logic [31:0] im_instr,
   output logic        f_valid,
   output logic [31:0] f_pc,
   output logic [31:0] f_instr,
   output logic [4:0]  f_exccode,
   output logic [31:0] f_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         fv_q, fv_d;
   logic [31:0]  fpc_q, fpc_d;
   logic [31:0]  finstr_q, finstr_d;
   logic [4:0]   fexc_q, fexc_d;
   logic [31:0]  fcnt_q, fcnt_d;
   logic         fault;

   pc_addr_check #(
      .IM_BASE  (IM_BASE),
      .IM_LIMIT (IM_LIMIT)
   ) u_pc_addr_check (
      .pc    (pc_q),
      .fault (fault)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         pc_q     <= PC_INIT;
         fv_q     <= 1'b0;
         fpc_q    <= 32'h0;
         finstr_q <= 32'h0;
         fexc_q   <= EXC_NONE;
         fcnt_q   <= 32'h0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         fv_q     <= fv_d;
         fpc_q    <= fpc_d;
         finstr_q <= finstr_d;
         fexc_q   <= fexc_d;
         fcnt_q   <= fcnt_d;
      end
   end

   // Redirects beat stall so a flush is never lost behind a decode hold.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      fv_d     = fv_q;
      fpc_d    = fpc_q;
      finstr_d = finstr_q;
      fexc_d   = fexc_q;
      fcnt_d   = fcnt_q;
      if (req) begin
         state_d = ST_BUBBLE;
         pc_d    = HANDLER_PC;
         fv_d    = 1'b0;
      end else if (eret) begin
         state_d = ST_BUBBLE;
         pc_d    = epc;
         fv_d    = 1'b0;
      end else if (stall) begin
         state_d = ST_RUN;
      end else begin
         state_d  = ST_RUN;
         fv_d     = 1'b1;
         fpc_d    = pc_q;
         finstr_d = fault ? 32'h0 : im_instr;
         fexc_d   = fault ? EXC_ADEL : EXC_NONE;
         fcnt_d   = fcnt_q + 32'd1;
         pc_d     = npc_sel ? npc : pc_q + 32'd4;
      end
   end

   assign im_addr   = pc_q;
   assign f_valid   = fv_q & (state_q == ST_RUN);
   assign f_pc      = fpc_q;
   assign f_instr   = finstr_q;
   assign f_exccode = fexc_q;
   assign f_count   = fcnt_q;

endmodule
